// File: rtl/ram_mp_pkg.sv
// Shared constants and sizing helpers for the multi-port RAM.
package ram_mp_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    // Width of a port index, never below one bit so single-port builds stay legal.
    function automatic int id_width(input int num_ports);
        int w;
        w = 1;
        while ((1 << w) < num_ports) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_mp_arbiter.sv
// Data-port arbiter: fixed priority (highest index) or round-robin with a wrap pointer.
module ram_mp_arbiter
    import ram_mp_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = ARB_FIXED,
    parameter int ID_W      = id_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic [ID_W-1:0]      ptr_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] win_id;
    logic            any_req;
    logic            found;
    int              idx;

    assign any_req = |req_i;

    always_comb begin
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        if (ARB_MODE == ARB_RR) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(ptr_q) + k) % NUM_PORTS;
                if (!found && req_i[idx]) begin
                    found  = 1'b1;
                    win_id = ID_W'(idx);
                end
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_i[i]) begin
                    win_id = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((ARB_MODE == ARB_RR) && any_req) begin
            ptr_d = (int'(win_id) == NUM_PORTS - 1) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o    = any_req ? (NUM_PORTS'(1) << win_id) : '0;
    assign gnt_id_o = win_id;
    assign ptr_o    = ptr_q;

endmodule

// File: rtl/ram_mp.sv
// Shared RAM: dedicated instruction read port plus arbitrated data read/write port,
// with per-port response routing and 1- or 2-cycle read latency.
module ram_mp
    import ram_mp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_DATA_PORTS = 2,
    parameter int READ_LATENCY   = 1,
    parameter int ARB_MODE       = ARB_FIXED
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                    instr_addr_i,
    output logic                                     instr_gnt_o,
    output logic                                     instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    instr_rdata_o,
    input  logic [NUM_DATA_PORTS-1:0]                data_req_i,
    input  logic [NUM_DATA_PORTS*ADDR_WIDTH-1:0]     data_addr_i,
    input  logic [NUM_DATA_PORTS-1:0]                data_we_i,
    input  logic [NUM_DATA_PORTS*(DATA_WIDTH/8)-1:0] data_be_i,
    input  logic [NUM_DATA_PORTS*DATA_WIDTH-1:0]     data_wdata_i,
    output logic [NUM_DATA_PORTS-1:0]                data_gnt_o,
    output logic [NUM_DATA_PORTS-1:0]                data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    data_rdata_o
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH);
    localparam int ID_W     = id_width(NUM_DATA_PORTS);
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_DATA_PORTS];
    logic [BE_WIDTH-1:0]   be_arr    [NUM_DATA_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_DATA_PORTS];

    for (genvar gi = 0; gi < NUM_DATA_PORTS; gi++) begin : g_unpack
        assign addr_arr[gi]  = data_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign be_arr[gi]    = data_be_i[gi*BE_WIDTH +: BE_WIDTH];
        assign wdata_arr[gi] = data_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [ID_W-1:0]       win_id;
    logic [ID_W-1:0]       arb_ptr;
    logic                  data_fire;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BE_WIDTH-1:0]   sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;

    ram_mp_arbiter #(
        .NUM_PORTS (NUM_DATA_PORTS),
        .ARB_MODE  (ARB_MODE),
        .ID_W      (ID_W)
    ) u_arbiter (
        .clk      (clk),
        .rst      (rst),
        .req_i    (data_req_i),
        .gnt_o    (data_gnt_o),
        .gnt_id_o (win_id),
        .ptr_o    (arb_ptr)
    );

    assign data_fire = |data_req_i;
    assign sel_we    = data_we_i[win_id];
    assign sel_addr  = addr_arr[win_id];
    assign sel_be    = be_arr[win_id];
    assign sel_wdata = wdata_arr[win_id];

    assign instr_gnt_o = instr_req_i;

    // Behavioural two-port array; both reads sample pre-edge contents (read-first).
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] instr_rd_q;
    logic [DATA_WIDTH-1:0] data_rd_q;

    always_ff @(posedge clk) begin
        if (data_fire && sel_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (sel_be[b]) begin
                    mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_rd_q <= '0;
            data_rd_q  <= '0;
        end else begin
            if (instr_req_i) begin
                instr_rd_q <= mem[instr_addr_i];
            end
            if (data_fire && !sel_we) begin
                data_rd_q <= mem[sel_addr];
            end
        end
    end

    // Response tracking: valid + winner id per latency stage, flushed by reset.
    logic            pipe_vld_q  [READ_LATENCY];
    logic [ID_W-1:0] pipe_id_q   [READ_LATENCY];
    logic            instr_vld_q [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_vld_q[s]  <= 1'b0;
                pipe_id_q[s]   <= '0;
                instr_vld_q[s] <= 1'b0;
            end
        end else begin
            pipe_vld_q[0]  <= data_fire;
            pipe_id_q[0]   <= win_id;
            instr_vld_q[0] <= instr_req_i;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_vld_q[s]  <= pipe_vld_q[s-1];
                pipe_id_q[s]   <= pipe_id_q[s-1];
                instr_vld_q[s] <= instr_vld_q[s-1];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_out_reg
        logic [DATA_WIDTH-1:0] instr_out_q;
        logic [DATA_WIDTH-1:0] data_out_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                instr_out_q <= '0;
                data_out_q  <= '0;
            end else begin
                instr_out_q <= instr_rd_q;
                data_out_q  <= data_rd_q;
            end
        end

        assign instr_rdata_o = instr_out_q;
        assign data_rdata_o  = data_out_q;
    end else begin : g_out_direct
        assign instr_rdata_o = instr_rd_q;
        assign data_rdata_o  = data_rd_q;
    end

    assign instr_rvalid_o = instr_vld_q[READ_LATENCY-1];

    for (genvar gi = 0; gi < NUM_DATA_PORTS; gi++) begin : g_rvalid
        assign data_rvalid_o[gi] = pipe_vld_q[READ_LATENCY-1] &&
                                   (pipe_id_q[READ_LATENCY-1] == ID_W'(gi));
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(data_gnt_o));
    assert property (@(posedge clk) disable iff (rst) int'(arb_ptr) < NUM_DATA_PORTS);

endmodule

// File: tb/tb_ram_mp.sv
// Directed bench: instance A (2 ports, fixed priority, latency 1),
// instance B (3 ports, round-robin, latency 2).
module tb_ram_mp;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Instance A signals
    logic        a_instr_req;
    logic [9:0]  a_instr_addr;
    logic        a_instr_gnt;
    logic        a_instr_rvalid;
    logic [31:0] a_instr_rdata;
    logic [1:0]  a_req;
    logic [19:0] a_addr;
    logic [1:0]  a_we;
    logic [7:0]  a_be;
    logic [63:0] a_wdata;
    logic [1:0]  a_gnt;
    logic [1:0]  a_rvalid;
    logic [31:0] a_rdata;

    // Instance B signals
    logic        b_instr_req;
    logic [9:0]  b_instr_addr;
    logic        b_instr_gnt;
    logic        b_instr_rvalid;
    logic [31:0] b_instr_rdata;
    logic [2:0]  b_req;
    logic [29:0] b_addr;
    logic [2:0]  b_we;
    logic [11:0] b_be;
    logic [95:0] b_wdata;
    logic [2:0]  b_gnt;
    logic [2:0]  b_rvalid;
    logic [31:0] b_rdata;

    ram_mp #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_DATA_PORTS(2), .READ_LATENCY(1), .ARB_MODE(0)
    ) dut_a (
        .clk(clk), .rst(rst_a),
        .instr_req_i(a_instr_req), .instr_addr_i(a_instr_addr), .instr_gnt_o(a_instr_gnt),
        .instr_rvalid_o(a_instr_rvalid), .instr_rdata_o(a_instr_rdata),
        .data_req_i(a_req), .data_addr_i(a_addr), .data_we_i(a_we), .data_be_i(a_be),
        .data_wdata_i(a_wdata), .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata)
    );

    ram_mp #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_DATA_PORTS(3), .READ_LATENCY(2), .ARB_MODE(1)
    ) dut_b (
        .clk(clk), .rst(rst_b),
        .instr_req_i(b_instr_req), .instr_addr_i(b_instr_addr), .instr_gnt_o(b_instr_gnt),
        .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata),
        .data_req_i(b_req), .data_addr_i(b_addr), .data_we_i(b_we), .data_be_i(b_be),
        .data_wdata_i(b_wdata), .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata)
    );

    // Single data access on instance A; checks same-cycle grant and rvalid one cycle later.
    task automatic a_access(input int p, input logic we, input logic [3:0] be, input logic [9:0] addr,
                            input logic [31:0] wd, input string tag, output logic [31:0] rd);
        @(negedge clk);
        a_req = '0;
        a_req[p] = 1'b1;
        a_we[p] = we;
        a_be[p*4 +: 4] = be;
        a_addr[p*10 +: 10] = addr;
        a_wdata[p*32 +: 32] = wd;
        #1 check({tag, "_gnt"}, a_gnt, 64'(1 << p));
        @(negedge clk);
        a_req = '0;
        #1 check({tag, "_rvalid"}, a_rvalid, 64'(1 << p));
        rd = a_rdata;
    endtask

    task automatic a_ifetch(input logic [9:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        a_instr_req = 1'b1;
        a_instr_addr = addr;
        #1 check({tag, "_ignt"}, a_instr_gnt, 1);
        @(negedge clk);
        a_instr_req = 1'b0;
        #1 check({tag, "_irvalid"}, a_instr_rvalid, 1);
        check({tag, "_irdata"}, a_instr_rdata, exp);
    endtask

    logic [31:0] rd;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_instr_req = 0; a_instr_addr = '0; a_req = '0; a_addr = '0; a_we = '0; a_be = '0; a_wdata = '0;
        b_instr_req = 0; b_instr_addr = '0; b_req = '0; b_addr = '0; b_we = '0; b_be = '0; b_wdata = '0;

        repeat (2) @(negedge clk);
        #1 check("rst_a_rvalid", {a_instr_rvalid, a_rvalid}, 0);
        check("rst_b_rvalid", {b_instr_rvalid, b_rvalid}, 0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Single write then read
        a_access(0, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF, "wr005", rd);
        a_access(0, 1'b0, 4'hF, 10'h005, 32'h0, "rd005", rd);
        check("rd005_data", rd, 32'hDEADBEEF);

        // Partial write: bytes 0 and 2 replaced
        a_access(0, 1'b1, 4'hF, 10'h010, 32'h11223344, "wr010", rd);
        a_access(1, 1'b1, 4'b0101, 10'h010, 32'hAABBCCDD, "wr010p", rd);
        a_access(0, 1'b0, 4'hF, 10'h010, 32'h0, "rd010", rd);
        check("rd010_data", rd, 32'h11BB33DD);

        // Write with no byte enables: granted and answered, contents untouched
        a_access(1, 1'b1, 4'h0, 10'h005, 32'hFFFFFFFF, "wrbe0", rd);
        a_access(1, 1'b0, 4'hF, 10'h005, 32'h0, "rdbe0", rd);
        check("rdbe0_data", rd, 32'hDEADBEEF);

        // Fixed priority: port 1 beats port 0
        @(negedge clk);
        a_req = 2'b11; a_we = 2'b00;
        a_addr = {10'h005, 10'h010};
        #1 check("fp_gnt1", a_gnt, 2'b10);
        @(negedge clk);
        a_req = 2'b01;
        #1 check("fp_gnt0", a_gnt, 2'b01);
        check("fp_rv1", a_rvalid, 2'b10);
        check("fp_rd1", a_rdata, 32'hDEADBEEF);
        @(negedge clk);
        a_req = 2'b00;
        #1 check("fp_rv0", a_rvalid, 2'b01);
        check("fp_rd0", a_rdata, 32'h11BB33DD);
        @(negedge clk);
        #1 check("fp_idle", a_rvalid, 2'b00);
        check("fp_iidle", a_instr_rvalid, 0);

        // Collision: instruction read sees old data in the write cycle
        a_access(0, 1'b1, 4'hF, 10'h020, 32'h12345678, "wr020", rd);
        @(negedge clk);
        a_req = 2'b01; a_we = 2'b01; a_be = 8'h0F; a_addr = {10'h0, 10'h020}; a_wdata = {32'h0, 32'h0000CAFE};
        a_instr_req = 1'b1; a_instr_addr = 10'h020;
        #1 check("col_gnt", a_gnt, 2'b01);
        @(negedge clk);
        a_req = '0; a_instr_req = 1'b0;
        #1 check("col_irvalid", a_instr_rvalid, 1);
        check("col_irdata", a_instr_rdata, 32'h12345678);
        check("col_drvalid", a_rvalid, 2'b01);
        a_ifetch(10'h020, 32'h0000CAFE, "col_after");

        // Back-to-back: read of the address written the cycle before sees new data
        @(negedge clk);
        a_req = 2'b01; a_we = 2'b01; a_be = 8'h0F; a_addr = {10'h0, 10'h030}; a_wdata = {32'h0, 32'h000055AA};
        #1 check("b2b_gnt_w", a_gnt, 2'b01);
        @(negedge clk);
        a_we = 2'b00;
        #1 check("b2b_gnt_r", a_gnt, 2'b01);
        check("b2b_rv_w", a_rvalid, 2'b01);
        @(negedge clk);
        a_req = '0;
        #1 check("b2b_rv_r", a_rvalid, 2'b01);
        check("b2b_rd", a_rdata, 32'h000055AA);

        // Round-robin on B: all three ports write continuously
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            b_req[p] = 1'b1;
            b_we[p] = 1'b1;
            b_be[p*4 +: 4] = 4'hF;
            b_addr[p*10 +: 10] = 10'h100 + 10'(p);
            b_wdata[p*32 +: 32] = 32'hB000_0000 | 32'(p);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 6) b_req = '0;
            #1;
            if (k < 6) check($sformatf("rr_gnt%0d", k), b_gnt, 64'(1 << (k % 3)));
            else check($sformatf("rr_gnt%0d", k), b_gnt, 0);
            if (k >= 2) check($sformatf("rr_rv%0d", k), b_rvalid, 64'(1 << ((k - 2) % 3)));
            else check($sformatf("rr_rv%0d", k), b_rvalid, 0);
            @(negedge clk);
        end
        #1 check("rr_rv_idle", b_rvalid, 0);

        // Latency-2 data read on port 2
        @(negedge clk);
        b_req = 3'b100; b_we = 3'b000; b_addr[20 +: 10] = 10'h101;
        #1 check("l2_gnt", b_gnt, 3'b100);
        @(negedge clk);
        b_req = '0;
        #1 check("l2_rv_early", b_rvalid, 0);
        @(negedge clk);
        #1 check("l2_rv", b_rvalid, 3'b100);
        check("l2_rd", b_rdata, 32'hB000_0001);

        // Latency-2 instruction read
        @(negedge clk);
        b_instr_req = 1'b1; b_instr_addr = 10'h102;
        @(negedge clk);
        b_instr_req = 1'b0;
        #1 check("l2_irv_early", b_instr_rvalid, 0);
        @(negedge clk);
        #1 check("l2_irv", b_instr_rvalid, 1);
        check("l2_ird", b_instr_rdata, 32'hB000_0002);

        // Reset one cycle after a granted read discards its response
        @(negedge clk);
        b_req = 3'b001; b_addr[0 +: 10] = 10'h100;
        #1 check("mid_gnt", b_gnt, 3'b001);
        @(negedge clk);
        b_req = '0;
        rst_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("mid_rst_rv%0d", c), {b_instr_rvalid, b_rvalid}, 0);
            @(negedge clk);
        end
        rst_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("mid_post_rv%0d", c), {b_instr_rvalid, b_rvalid}, 0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
